// File: rtl/pipeline_ctl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctl_defs
//   Shared definitions for the pipeline control unit: forward-select
//   encodings and the multi-cycle FSM state type.
// ----------------------------------------------------------------------------
package pipeline_ctl_defs;

    // Forward-select encodings driven onto forward_a / forward_b.
    localparam logic [1:0] FWD_NONE = 2'd0;  // register file
    localparam logic [1:0] FWD_S4   = 2'd1;  // MEM-stage result
    localparam logic [1:0] FWD_S5   = 2'd2;  // WB-stage data

    // Multi-cycle EX operation FSM.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MULBUSY = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctl_fwd_sel.sv
// ----------------------------------------------------------------------------
// fwd_sel
//   Forward-select for one ALU operand. The younger producer (MEM) wins over
//   the older one (WB); register 0 is hard-wired and never forwards.
//
// Ports
//   src_i         operand source register of the EX instruction
//   regwrite_s4_i MEM instruction writes a register
//   wrreg_s4_i    MEM destination register
//   regwrite_s5_i WB instruction writes a register
//   wrreg_s5_i    WB destination register
//   sel_o         FWD_NONE / FWD_S4 / FWD_S5
// ----------------------------------------------------------------------------
module fwd_sel
    import pipeline_ctl_defs::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] src_i,
    input  logic          regwrite_s4_i,
    input  logic [RW-1:0] wrreg_s4_i,
    input  logic          regwrite_s5_i,
    input  logic [RW-1:0] wrreg_s5_i,
    output logic [1:0]    sel_o
);

    logic hit_s4;
    logic hit_s5;

    assign hit_s4 = regwrite_s4_i && (wrreg_s4_i != '0) && (wrreg_s4_i == src_i);
    assign hit_s5 = regwrite_s5_i && (wrreg_s5_i != '0) && (wrreg_s5_i == src_i);

    assign sel_o = hit_s4 ? FWD_S4 :
                   hit_s5 ? FWD_S5 : FWD_NONE;

endmodule

// File: rtl/pipeline_ctl.sv
// ----------------------------------------------------------------------------
// pipeline_ctl
//   Control unit for the in-order MIPS pipeline. Produces per-boundary hold
//   and clear, the PC hold and the ALU forward selects. Resolves taken-branch
//   flushes (highest priority), multi-cycle EX ops via a RUN/MULBUSY FSM, and
//   load-use stalls (lowest priority).
//
// Parameters
//   NSTAGE   pipeline depth; boundary i sits between stage i and i+1
//   BR_STAGE stage producing pcsrc (3..NSTAGE-1)
//   RW       register-address width
//   MUL_LAT  EX occupancy of a multi-cycle op (>=1)
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   rs_s2/rt_s2, uses_rs/rt_s2   ID sources and whether they are read
//   rs_s3/rt_s3, memread_s3      EX sources; EX load writes rt_s3
//   regwrite_s4/5, wrreg_s4/5    MEM / WB register writers
//   multi_start_s3               EX holds a multi-cycle op
//   pcsrc                        taken branch resolved in BR_STAGE
//   pc_hold, hold, clear         PC / boundary controls (bit i-1 = boundary i)
//   forward_a, forward_b         ALU operand forward selects
//   busy, mul_done               FSM in MULBUSY / last EX cycle of the op
//
// Optional build macro PIPELINE_CTL_STATS_EN adds saturating 32-bit
// counters stall_cycles (cycles with pc_hold) and flush_count (pcsrc cycles).
// ----------------------------------------------------------------------------
module pipeline_ctl
    import pipeline_ctl_defs::*;
#(
    parameter int NSTAGE   = 5,
    parameter int BR_STAGE = 4,
    parameter int RW       = 5,
    parameter int MUL_LAT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RW-1:0]     rs_s2,
    input  logic [RW-1:0]     rt_s2,
    input  logic              uses_rs_s2,
    input  logic              uses_rt_s2,
    input  logic [RW-1:0]     rs_s3,
    input  logic [RW-1:0]     rt_s3,
    input  logic              memread_s3,
    input  logic              regwrite_s4,
    input  logic              regwrite_s5,
    input  logic [RW-1:0]     wrreg_s4,
    input  logic [RW-1:0]     wrreg_s5,
    input  logic              multi_start_s3,
    input  logic              pcsrc,
    output logic              pc_hold,
    output logic [NSTAGE-2:0] hold,
    output logic [NSTAGE-2:0] clear,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              busy,
    output logic              mul_done
`ifdef PIPELINE_CTL_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    localparam int       CW          = $clog2(MUL_LAT + 1);
    localparam bit       MULTI_CYCLE = (MUL_LAT > 1);
    // Branch resolved past EX: anything in EX is younger and must be killed.
    localparam bit       BR_LATE     = (BR_STAGE > 3);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_CYCLE ? MUL_LAT - 2 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic mul_entry;
    logic mul_abort;
    logic multi_stall;
    logic lu_stall;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign mul_entry   = MULTI_CYCLE && (state_q == ST_RUN) && multi_start_s3 && !pcsrc;
    assign mul_abort   = BR_LATE && (state_q == ST_MULBUSY) && pcsrc;
    assign multi_stall = mul_entry || ((state_q == ST_MULBUSY) && (cnt_q != '0));
    assign lu_stall    = memread_s3 && (rt_s3 != '0) &&
                         ((uses_rs_s2 && (rs_s2 == rt_s3)) ||
                          (uses_rt_s2 && (rt_s2 == rt_s3)));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mul_entry) begin
                    state_d = ST_MULBUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_MULBUSY: begin
                if (mul_abort || (cnt_q == '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline controls: reset > flush > multi-cycle stall > load-use
    // ------------------------------------------------------------------
    always_comb begin
        pc_hold = 1'b0;
        hold    = '0;
        clear   = '0;
        if (reset) begin
            clear = '1;
        end else if (pcsrc) begin
            for (int i = 0; i < NSTAGE - 1; i++) begin
                if (i < BR_STAGE - 1) clear[i] = 1'b1;
            end
        end else if (multi_stall) begin
            pc_hold = 1'b1;
            hold[0] = 1'b1;
            hold[1] = 1'b1;
            clear[2] = 1'b1;
        end else if (lu_stall) begin
            pc_hold  = 1'b1;
            hold[0]  = 1'b1;
            clear[1] = 1'b1;
        end
    end

    // With MUL_LAT==1 the op completes in its single EX cycle while in RUN.
    always_comb begin
        mul_done = 1'b0;
        if (!reset) begin
            if (MULTI_CYCLE) mul_done = (state_q == ST_MULBUSY) && (cnt_q == '0) && !mul_abort;
            else             mul_done = (state_q == ST_RUN) && multi_start_s3 && !pcsrc;
        end
    end

    assign busy = (state_q == ST_MULBUSY) && !reset;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_sel #(.RW(RW)) u_fwd_a (
        .src_i         (rs_s3),
        .regwrite_s4_i (regwrite_s4),
        .wrreg_s4_i    (wrreg_s4),
        .regwrite_s5_i (regwrite_s5),
        .wrreg_s5_i    (wrreg_s5),
        .sel_o         (fwd_a_raw)
    );

    fwd_sel #(.RW(RW)) u_fwd_b (
        .src_i         (rt_s3),
        .regwrite_s4_i (regwrite_s4),
        .wrreg_s4_i    (wrreg_s4),
        .regwrite_s5_i (regwrite_s5),
        .wrreg_s5_i    (wrreg_s5),
        .sel_o         (fwd_b_raw)
    );

    assign forward_a = reset ? FWD_NONE : fwd_a_raw;
    assign forward_b = reset ? FWD_NONE : fwd_b_raw;

`ifdef PIPELINE_CTL_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (pcsrc   && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctl
//   Directed bench for pipeline_ctl (NSTAGE=5, BR_STAGE=4, MUL_LAT=4).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Counter checks compile when PIPELINE_CTL_STATS_EN is set.
// ----------------------------------------------------------------------------
module tb_pipeline_ctl;

    localparam int NSTAGE   = 5;
    localparam int BR_STAGE = 4;
    localparam int RW       = 5;
    localparam int MUL_LAT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [RW-1:0]     rs_s2, rt_s2, rs_s3, rt_s3, wrreg_s4, wrreg_s5;
    logic              uses_rs_s2, uses_rt_s2, memread_s3;
    logic              regwrite_s4, regwrite_s5, multi_start_s3, pcsrc;
    logic              pc_hold, busy, mul_done;
    logic [NSTAGE-2:0] hold, clear;
    logic [1:0]        forward_a, forward_b;
`ifdef PIPELINE_CTL_STATS_EN
    logic [31:0]       stall_cycles, flush_count;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctl #(
        .NSTAGE(NSTAGE), .BR_STAGE(BR_STAGE), .RW(RW), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rs_s2          (rs_s2),
        .rt_s2          (rt_s2),
        .uses_rs_s2     (uses_rs_s2),
        .uses_rt_s2     (uses_rt_s2),
        .rs_s3          (rs_s3),
        .rt_s3          (rt_s3),
        .memread_s3     (memread_s3),
        .regwrite_s4    (regwrite_s4),
        .regwrite_s5    (regwrite_s5),
        .wrreg_s4       (wrreg_s4),
        .wrreg_s5       (wrreg_s5),
        .multi_start_s3 (multi_start_s3),
        .pcsrc          (pcsrc),
        .pc_hold        (pc_hold),
        .hold           (hold),
        .clear          (clear),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .busy           (busy),
        .mul_done       (mul_done)
`ifdef PIPELINE_CTL_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic ph, input logic [3:0] h, input logic [3:0] c);
        check({tag, ".pc_hold"}, 32'(pc_hold), 32'(ph));
        check({tag, ".hold"},    32'(hold),    32'(h));
        check({tag, ".clear"},   32'(clear),   32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs_s2 = '0; rt_s2 = '0; rs_s3 = '0; rt_s3 = '0;
        wrreg_s4 = '0; wrreg_s5 = '0;
        uses_rs_s2 = 0; uses_rt_s2 = 0; memread_s3 = 0;
        regwrite_s4 = 0; regwrite_s5 = 0; multi_start_s3 = 0; pcsrc = 0;
    endtask

    task automatic set_load_use();
        memread_s3 = 1; rt_s3 = 5'd1; rs_s2 = 5'd1; uses_rs_s2 = 1;
    endtask

    initial begin
        // ---------------- reset, with a forwarding match present
        idle_inputs();
        reset = 1;
        regwrite_s4 = 1; wrreg_s4 = 5'd3; rs_s3 = 5'd3;
        sample();
        check_ctl("rst", 1'b0, 4'b0000, 4'b1111);
        check("rst.fwd_a",    32'(forward_a), 32'd0);
        check("rst.busy",     32'(busy),      32'd0);
        check("rst.mul_done", 32'(mul_done),  32'd0);

        tick(); reset = 0; idle_inputs(); sample();
        check_ctl("idle", 1'b0, 4'b0000, 4'b0000);
        check("idle.busy", 32'(busy), 32'd0);

        // ---------------- forwarding
        tick();
        regwrite_s4 = 1; wrreg_s4 = 5'd3; regwrite_s5 = 1; wrreg_s5 = 5'd3; rs_s3 = 5'd3; rt_s3 = 5'd6;
        sample();
        check("fwd.mem_wins", 32'(forward_a), 32'd1);
        check("fwd.b_nomatch", 32'(forward_b), 32'd0);
        tick(); regwrite_s4 = 0; sample();
        check("fwd.wb", 32'(forward_a), 32'd2);
        tick(); regwrite_s4 = 1; wrreg_s4 = 5'd0; wrreg_s5 = 5'd0; rs_s3 = 5'd0; sample();
        check("fwd.r0", 32'(forward_a), 32'd0);
        tick(); regwrite_s4 = 0; wrreg_s4 = 5'd7; regwrite_s5 = 1; wrreg_s5 = 5'd7; rt_s3 = 5'd7; sample();
        check("fwd.b_wb", 32'(forward_b), 32'd2);

        // ---------------- load-use
        tick(); idle_inputs(); set_load_use(); sample();
        check_ctl("lu.rs", 1'b1, 4'b0001, 4'b0010);
        tick(); uses_rs_s2 = 0; sample();
        check_ctl("lu.unused", 1'b0, 4'b0000, 4'b0000);
        tick(); rt_s2 = 5'd1; uses_rt_s2 = 1; sample();
        check_ctl("lu.rt", 1'b1, 4'b0001, 4'b0010);
        tick(); idle_inputs(); memread_s3 = 1; rt_s3 = 5'd0; rs_s2 = 5'd0; uses_rs_s2 = 1; sample();
        check_ctl("lu.r0", 1'b0, 4'b0000, 4'b0000);

        // ---------------- multi-cycle op, multi_start held through the op
        tick(); idle_inputs(); multi_start_s3 = 1; sample();            // t
        check_ctl("mul.t0", 1'b1, 4'b0011, 4'b0100);
        check("mul.t0.busy", 32'(busy), 32'd0);
        check("mul.t0.done", 32'(mul_done), 32'd0);
        tick(); sample();                                                // t+1
        check_ctl("mul.t1", 1'b1, 4'b0011, 4'b0100);
        check("mul.t1.busy", 32'(busy), 32'd1);
        tick(); set_load_use(); sample();                                // t+2, load-use suppressed
        check_ctl("mul.t2", 1'b1, 4'b0011, 4'b0100);
        check("mul.t2.done", 32'(mul_done), 32'd0);
        tick(); idle_inputs(); multi_start_s3 = 1; sample();            // t+3
        check_ctl("mul.t3", 1'b0, 4'b0000, 4'b0000);
        check("mul.t3.busy", 32'(busy), 32'd1);
        check("mul.t3.done", 32'(mul_done), 32'd1);
        tick(); multi_start_s3 = 0; sample();                            // t+4
        check("mul.t4.busy", 32'(busy), 32'd0);
        check("mul.t4.done", 32'(mul_done), 32'd0);

        // ---------------- flush aborts an in-flight op
        tick(); multi_start_s3 = 1; sample();                            // t
        check("abort.t0.ph", 32'(pc_hold), 32'd1);
        tick(); multi_start_s3 = 0; pcsrc = 1; sample();                 // t+1
        check_ctl("abort.t1", 1'b0, 4'b0000, 4'b0111);
        check("abort.t1.done", 32'(mul_done), 32'd0);
        tick(); pcsrc = 0; sample();                                     // t+2
        check("abort.t2.busy", 32'(busy), 32'd0);
        check("abort.t2.done", 32'(mul_done), 32'd0);
        check("abort.t2.ph",   32'(pc_hold), 32'd0);
        tick(); sample();                                                // t+3
        check("abort.t3.done", 32'(mul_done), 32'd0);

        // ---------------- flush beats load-use and multi start in RUN
        tick(); set_load_use(); pcsrc = 1; sample();
        check_ctl("flush.lu", 1'b0, 4'b0000, 4'b0111);
        tick(); idle_inputs(); pcsrc = 1; multi_start_s3 = 1; sample();
        check_ctl("flush.mul", 1'b0, 4'b0000, 4'b0111);
        check("flush.mul.done", 32'(mul_done), 32'd0);
        tick(); idle_inputs(); sample();
        check("flush.mul.busy", 32'(busy), 32'd0);

        // ---------------- reset mid-op
        tick(); multi_start_s3 = 1; sample();
        check("rmid.t0.ph", 32'(pc_hold), 32'd1);
        tick(); multi_start_s3 = 0; reset = 1; sample();
        check_ctl("rmid.t1", 1'b0, 4'b0000, 4'b1111);
        check("rmid.t1.busy", 32'(busy), 32'd0);
        check("rmid.t1.done", 32'(mul_done), 32'd0);
        tick(); reset = 0; sample();
        check_ctl("rmid.t2", 1'b0, 4'b0000, 4'b0000);
        check("rmid.t2.busy", 32'(busy), 32'd0);
        tick(); sample();
        check("rmid.t3.done", 32'(mul_done), 32'd0);

`ifdef PIPELINE_CTL_STATS_EN
        // ---------------- statistics counters
        check("stats.rst.stall", stall_cycles, 32'd0);
        check("stats.rst.flush", flush_count,  32'd0);
        tick(); multi_start_s3 = 1;
        tick(); multi_start_s3 = 0;
        tick();
        tick();
        tick(); pcsrc = 1;
        tick(); pcsrc = 0;
        sample();
        check("stats.stall", stall_cycles, 32'd3);
        check("stats.flush", flush_count,  32'd1);

        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        force dut.flush_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        release dut.flush_cnt_q;
        tick(); set_load_use();
        tick();
        tick(); idle_inputs(); pcsrc = 1;
        tick();
        tick(); pcsrc = 0;
        sample();
        check("stats.sat.stall", stall_cycles, 32'hFFFF_FFFF);
        check("stats.sat.flush", flush_count,  32'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
